// File: rtl/sync_queue_if.sv
// Producer/consumer handshake bundle for sync_queue: push/pop requests in,
// head data, occupancy and error pulses out.
interface sync_queue_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  write_data;
    logic [WIDTH-1:0]  read_data;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, write_data,
        input  read_data, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, write_data,
        output read_data, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/sync_queue.sv
// Single-clock FIFO with registered head output, occupancy, full/empty flags
// and one-cycle error pulses for rejected push/pop requests.
module sync_queue #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    sync_queue_if.slave  bus
);
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]  rd_q;
    logic              empty_q, full_q, ovf_q, udf_q;
    logic              push_ok, pop_ok;

    // A push into a full queue is still accepted when a pop frees the head slot.
    assign push_ok = bus.push & (~full_q | bus.pop);
    assign pop_ok  = bus.pop & ~empty_q;

    always_comb begin
        cnt_nxt = cnt;
        if (push_ok && !pop_ok)
            cnt_nxt = cnt + 1'b1;
        else if (pop_ok && !push_ok)
            cnt_nxt = cnt - 1'b1;
    end

    // Storage is not reset; contents are don't-care after rst.
    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            mem[wr_ptr] <= bus.write_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            rd_q    <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                rd_q   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt     <= cnt_nxt;
            empty_q <= (cnt_nxt == '0);
            full_q  <= (cnt_nxt == (ADDR_W+1)'(DEPTH));
            ovf_q   <= bus.push & full_q & ~bus.pop;
            udf_q   <= bus.pop & empty_q;
        end
    end

    assign bus.read_data = rd_q;
    assign bus.count     = cnt;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
endmodule

// File: tb/tb_sync_queue.sv
// Directed bench for sync_queue (DEPTH=8, WIDTH=8) with hand-computed expectations.
module tb_sync_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    sync_queue_if #(.WIDTH(8), .ADDR_W(3)) q_if ();

    sync_queue #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (q_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1ns after the edge.
    task automatic step(input logic p, input logic pp, input logic [7:0] d);
        q_if.push       = p;
        q_if.pop        = pp;
        q_if.write_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int c, input logic e,
                             input logic f, input logic ov, input logic un);
        chk({tag, ".count"}, 32'(q_if.count), 32'(c));
        chk({tag, ".empty"}, 32'(q_if.empty), 32'(e));
        chk({tag, ".full"},  32'(q_if.full),  32'(f));
        chk({tag, ".ovf"},   32'(q_if.overflow),  32'(ov));
        chk({tag, ".udf"},   32'(q_if.underflow), 32'(un));
    endtask

    initial begin
        q_if.push = 1'b0;
        q_if.pop = 1'b0;
        q_if.write_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        step(0, 0, 8'h00);
        chk_state("reset", 0, 1, 0, 0, 0);
        chk("reset.rd", 32'(q_if.read_data), 32'h00);

        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 8'(i));
            chk("fill.count", 32'(q_if.count), 32'(i));
        end
        chk_state("full", 8, 0, 1, 0, 0);

        step(1, 0, 8'h09);
        chk_state("ovf", 8, 0, 1, 1, 0);
        step(0, 0, 8'h00);
        chk("ovf.clear", 32'(q_if.overflow), 32'h0);

        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 8'h00);
            chk("drain.rd", 32'(q_if.read_data), 32'(i));
            chk("drain.count", 32'(q_if.count), 32'(8 - i));
        end
        chk_state("drained", 0, 1, 0, 0, 0);

        step(0, 1, 8'h00);
        chk_state("udf", 0, 1, 0, 0, 1);
        chk("udf.rd", 32'(q_if.read_data), 32'h08);
        step(0, 0, 8'h00);
        chk("udf.clear", 32'(q_if.underflow), 32'h0);

        // Pointers sit at 6 after this, so the next batch wraps past index 7.
        for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h30 + i));
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 8'h00);
            chk("pre.rd", 32'(q_if.read_data), 32'(8'h30 + i));
        end
        for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h10 + i));
        chk("wrap.count6", 32'(q_if.count), 32'd6);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 8'h00);
            chk("wrap.rd", 32'(q_if.read_data), 32'(8'h10 + i));
        end
        chk_state("wrap.end", 0, 1, 0, 0, 0);

        step(1, 0, 8'hA0);
        step(1, 0, 8'hA1);
        step(1, 0, 8'hA2);
        step(1, 1, 8'hB0);
        chk("pp.mid.rd", 32'(q_if.read_data), 32'hA0);
        chk("pp.mid.count", 32'(q_if.count), 32'd3);

        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i));
        chk_state("pp.full.pre", 8, 0, 1, 0, 0);
        step(1, 1, 8'hD0);
        chk_state("pp.full", 8, 0, 1, 0, 0);
        chk("pp.full.rd", 32'(q_if.read_data), 32'hA1);

        begin
            logic [7:0] exp_q [8];
            exp_q = '{8'hA2, 8'hB0, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD0};
            for (int i = 0; i < 8; i++) begin
                step(0, 1, 8'h00);
                chk("pp.drain.rd", 32'(q_if.read_data), 32'(exp_q[i]));
            end
        end
        chk_state("pp.drained", 0, 1, 0, 0, 0);

        step(1, 1, 8'hE0);
        chk_state("pp.empty", 1, 0, 0, 0, 1);
        chk("pp.empty.rd", 32'(q_if.read_data), 32'hD0);
        step(0, 1, 8'h00);
        chk("pp.empty.pop", 32'(q_if.read_data), 32'hE0);
        chk("pp.empty.count", 32'(q_if.count), 32'd0);

        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h50 + i));
        chk("mid.count5", 32'(q_if.count), 32'd5);
        q_if.push = 1'b0;
        q_if.pop = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_state("arst", 0, 1, 0, 0, 0);
        chk("arst.rd", 32'(q_if.read_data), 32'h00);
        step(1, 1, 8'h66);
        chk_state("arst.hold", 0, 1, 0, 0, 0);
        rst = 1'b0;

        step(0, 1, 8'h00);
        chk_state("post.udf", 0, 1, 0, 0, 1);
        step(1, 0, 8'h77);
        chk("post.push", 32'(q_if.count), 32'd1);
        step(0, 1, 8'h00);
        chk("post.rd", 32'(q_if.read_data), 32'h77);
        chk_state("post.end", 0, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
